// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the three requesters, the arbiter and the unified memory macro.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_wmask;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  d_req, d_we, d_wmask, d_addr, d_wdata,
        input  f_req, f_addr,
        input  mem_rdata,
        output ld_gnt,
        output d_gnt, d_rvalid, d_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output d_req, d_we, d_wmask, d_addr, d_wdata,
        output f_req, f_addr,
        output mem_rdata,
        input  ld_gnt,
        input  d_gnt, d_rvalid, d_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  mem_en, mem_we, mem_wmask, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for loader, data path and instruction fetch.
// Fixed priority ld > d > f, with fetch promoted over data after MAX_WAIT consecutive denials.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int MAX_WAIT = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_D    = 2'd1,
        TAG_F    = 2'd2
    } tag_t;

    tag_t          tag_q, tag_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          f_urgent;

    logic          ld_g, d_g, f_g;
    logic          m_en, m_we;
    logic [3:0]    m_wmask;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;

    assign f_urgent = (starve_q == SW'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= TAG_NONE;
            starve_q <= '0;
        end else begin
            tag_q    <= tag_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        ld_g     = 1'b0;
        d_g      = 1'b0;
        f_g      = 1'b0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_wmask  = '0;
        m_addr   = '0;
        m_wdata  = '0;
        tag_d    = TAG_NONE;
        starve_d = starve_q;

        // Grants are gated by rst so nothing reaches the memory while reset is held.
        if (rst) begin
            if (bus.ld_req) begin
                ld_g = 1'b1;
            end else if (bus.f_req && f_urgent) begin
                f_g = 1'b1;
            end else if (bus.d_req) begin
                d_g = 1'b1;
            end else if (bus.f_req) begin
                f_g = 1'b1;
            end
        end

        if (ld_g) begin
            m_en    = 1'b1;
            m_we    = 1'b1;
            m_wmask = 4'hF;
            m_addr  = bus.ld_addr;
            m_wdata = bus.ld_wdata;
        end else if (d_g) begin
            m_en    = 1'b1;
            m_we    = bus.d_we;
            m_wmask = bus.d_we ? bus.d_wmask : 4'h0;
            m_addr  = bus.d_addr;
            m_wdata = bus.d_we ? bus.d_wdata : '0;
        end else if (f_g) begin
            m_en    = 1'b1;
            m_addr  = bus.f_addr;
        end

        if (d_g && !bus.d_we) begin
            tag_d = TAG_D;
        end else if (f_g) begin
            tag_d = TAG_F;
        end

        if (f_g || !bus.f_req) begin
            starve_d = '0;
        end else if (!f_urgent) begin
            starve_d = starve_q + SW'(1);
        end
    end

    assign bus.ld_gnt    = ld_g;
    assign bus.d_gnt     = d_g;
    assign bus.f_gnt     = f_g;
    assign bus.mem_en    = m_en;
    assign bus.mem_we    = m_we;
    assign bus.mem_wmask = m_wmask;
    assign bus.mem_addr  = m_addr;
    assign bus.mem_wdata = m_wdata;

    assign bus.d_rvalid  = (tag_q == TAG_D);
    assign bus.f_rvalid  = (tag_q == TAG_F);
    assign bus.d_rdata   = (tag_q == TAG_D) ? bus.mem_rdata : '0;
    assign bus.f_rdata   = (tag_q == TAG_F) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grant vectors from a table plus directed reset/starvation sequences;
// read returns are checked against a cycle-stamped scoreboard.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.AW(32)) bus ();

    mem_port_arbiter #(.AW(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // Memory stub: 1-cycle read latency, returns a filler pattern on non-read cycles.
    logic        pend_rd;
    logic [31:0] pend_addr;
    logic [31:0] rdata_q;
    initial begin
        pend_rd   = 1'b0;
        pend_addr = '0;
        rdata_q   = 32'hA5A5_A5A5;
    end
    always @(negedge clk) begin
        pend_rd   <= bus.mem_en && !bus.mem_we;
        pend_addr <= bus.mem_addr;
    end
    always @(posedge clk) rdata_q <= pend_rd ? mem_fn(pend_addr) : 32'hA5A5_A5A5;
    assign bus.mem_rdata = rdata_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int unsigned due;
        bit          is_f;
        logic [31:0] data;
    } rd_t;
    rd_t sbq[$];

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            logic        ed, ef;
            logic [31:0] edata;
            rd_t         it;
            ed = 1'b0; ef = 1'b0; edata = '0;
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_missing: due cyc %0d, now %0d", sbq[0].due, cyc);
                sbq.delete(0);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                it = sbq.pop_front();
                if (it.is_f) ef = 1'b1; else ed = 1'b1;
                edata = it.data;
            end
            chk("d_rvalid", {31'b0, bus.d_rvalid}, {31'b0, ed});
            chk("f_rvalid", {31'b0, bus.f_rvalid}, {31'b0, ef});
            chk("d_rdata", bus.d_rdata, ed ? edata : 32'h0);
            chk("f_rdata", bus.f_rdata, ef ? edata : 32'h0);
        end
    end

    typedef struct {
        logic        ld, d, dwe;
        logic [3:0]  mask;
        logic        f;
        int unsigned sel;   // 0 none, 1 ld, 2 d, 3 f
        logic        we;
        logic [3:0]  wm;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic d, input logic dwe, input logic [3:0] mask,
                                input logic f, input int unsigned sel, input logic we, input logic [3:0] wm);
        vec_t v;
        v.ld = ld; v.d = d; v.dwe = dwe; v.mask = mask; v.f = f;
        v.sel = sel; v.we = we; v.wm = wm;
        return v;
    endfunction

    int unsigned stepn = 0;
    bit ld_hold = 1'b0, d_hold = 1'b0, f_hold = 1'b0;

    task automatic step(input vec_t v, input string nm);
        logic [31:0] ea, ew;
        @(posedge clk);
        #1;
        stepn++;
        // A denied requester keeps its payload until granted.
        if (!ld_hold) begin
            bus.ld_addr  = 32'h8000_0400 + (stepn << 2);
            bus.ld_wdata = 32'hDEAD_BEEF;
        end
        if (!d_hold) begin
            bus.d_addr  = 32'h8000_0100 + (stepn << 2);
            bus.d_wdata = 32'h1234_5600 + stepn;
        end
        if (!f_hold) bus.f_addr = 32'h8000_0000 + (stepn << 2);
        bus.ld_req  = v.ld;
        bus.d_req   = v.d;
        bus.d_we    = v.dwe;
        bus.d_wmask = v.mask;
        bus.f_req   = v.f;
        @(negedge clk);
        case (v.sel)
            1: begin ea = bus.ld_addr; ew = bus.ld_wdata; end
            2: begin ea = bus.d_addr;  ew = bus.d_wdata;  end
            3: begin ea = bus.f_addr;  ew = 32'h0;        end
            default: begin ea = 32'h0; ew = 32'h0; end
        endcase
        chk({nm, ".ld_gnt"}, {31'b0, bus.ld_gnt}, {31'b0, v.sel == 1});
        chk({nm, ".d_gnt"},  {31'b0, bus.d_gnt},  {31'b0, v.sel == 2});
        chk({nm, ".f_gnt"},  {31'b0, bus.f_gnt},  {31'b0, v.sel == 3});
        chk({nm, ".mem_en"}, {31'b0, bus.mem_en}, {31'b0, v.sel != 0});
        chk({nm, ".mem_we"}, {31'b0, bus.mem_we}, {31'b0, v.we});
        chk({nm, ".mem_wmask"}, {28'b0, bus.mem_wmask}, {28'b0, v.wm});
        chk({nm, ".mem_addr"}, bus.mem_addr, ea);
        if (v.we) chk({nm, ".mem_wdata"}, bus.mem_wdata, ew);
        if (v.sel == 2 && !v.dwe) sbq.push_back('{due: cyc + 1, is_f: 1'b0, data: mem_fn(bus.d_addr)});
        if (v.sel == 3)           sbq.push_back('{due: cyc + 1, is_f: 1'b1, data: mem_fn(bus.f_addr)});
        ld_hold = v.ld && v.sel != 1;
        d_hold  = v.d  && v.sel != 2;
        f_hold  = v.f  && v.sel != 3;
    endtask

    vec_t tbl[15];

    initial begin
        //            ld d  dwe mask  f  sel we wm
        tbl[0]  = mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0);
        tbl[1]  = mk(0, 1, 0, 4'hF, 0, 2, 0, 4'h0);
        tbl[2]  = mk(0, 1, 0, 4'h0, 1, 2, 0, 4'h0);
        tbl[3]  = mk(0, 1, 1, 4'h3, 1, 2, 1, 4'h3);
        tbl[4]  = mk(1, 1, 1, 4'h3, 1, 1, 1, 4'hF);
        tbl[5]  = mk(0, 1, 1, 4'h3, 1, 2, 1, 4'h3);
        tbl[6]  = mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0);
        tbl[7]  = mk(1, 0, 0, 4'h0, 0, 1, 1, 4'hF);
        tbl[8]  = mk(0, 1, 1, 4'hC, 0, 2, 1, 4'hC);
        tbl[9]  = mk(1, 0, 0, 4'h0, 1, 1, 1, 4'hF);
        tbl[10] = mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0);
        tbl[11] = mk(0, 1, 0, 4'h0, 1, 2, 0, 4'h0);
        tbl[12] = mk(0, 1, 0, 4'h0, 1, 2, 0, 4'h0);
        tbl[13] = mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0);
        tbl[14] = mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0);

        rst = 1'b0;
        bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_wmask = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.f_req = 1'b1; bus.f_addr = 32'h8000_0000;

        // Reset held with a pending fetch: nothing may be granted.
        repeat (3) begin
            @(negedge clk);
            chk("rst.ld_gnt", {31'b0, bus.ld_gnt}, 32'h0);
            chk("rst.d_gnt",  {31'b0, bus.d_gnt},  32'h0);
            chk("rst.f_gnt",  {31'b0, bus.f_gnt},  32'h0);
            chk("rst.mem_en", {31'b0, bus.mem_en}, 32'h0);
            chk("rst.f_rvalid", {31'b0, bus.f_rvalid}, 32'h0);
            chk("rst.f_rdata", bus.f_rdata, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rel.f_gnt", {31'b0, bus.f_gnt}, 32'h1);
        chk("rel.mem_addr", bus.mem_addr, 32'h8000_0000);
        chk("rel.mem_we", {31'b0, bus.mem_we}, 32'h0);
        sbq.push_back('{due: cyc + 1, is_f: 1'b1, data: mem_fn(32'h8000_0000)});

        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Data load against fetch: d first, then f, each returning data the following cycle.
        step(mk(0, 1, 0, 4'h0, 1, 2, 0, 4'h0), "dvf0");
        step(mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0), "dvf1");
        step(mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0), "dvf2");

        // Starvation relief: four d grants, then f on the fifth, then d again.
        for (int i = 0; i < 4; i++) step(mk(0, 1, 0, 4'h0, 1, 2, 0, 4'h0), $sformatf("stv%0d", i));
        step(mk(0, 1, 0, 4'h0, 1, 3, 0, 4'h0), "stv4");
        step(mk(0, 1, 0, 4'h0, 1, 2, 0, 4'h0), "stv5");
        step(mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0), "stv6");

        // Loader gives no relief; the counter saturates and f wins once ld drops.
        for (int i = 0; i < 6; i++) step(mk(1, 0, 0, 4'h0, 1, 1, 1, 4'hF), $sformatf("sat%0d", i));
        step(mk(0, 1, 0, 4'h0, 1, 3, 0, 4'h0), "sat6");
        step(mk(0, 1, 0, 4'h0, 0, 2, 0, 4'h0), "sat7");
        step(mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0), "sat8");

        // Fetch granted, then reset pulsed mid-way through the return cycle.
        step(mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0), "kill0");
        sbq.delete(sbq.size() - 1);
        @(posedge clk);
        #1 bus.f_req = 1'b0;
        mon_en = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("kill.f_rvalid", {31'b0, bus.f_rvalid}, 32'h0);
        chk("kill.f_rdata", bus.f_rdata, 32'h0);
        @(negedge clk);
        chk("kill.f_rvalid_n", {31'b0, bus.f_rvalid}, 32'h0);
        chk("kill.mem_en", {31'b0, bus.mem_en}, 32'h0);
        #2 rst = 1'b1;
        mon_en = 1'b1;
        step(mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0), "kill1");
        step(mk(0, 0, 0, 4'h0, 1, 3, 0, 4'h0), "kill2");
        step(mk(0, 1, 0, 4'h0, 0, 2, 0, 4'h0), "kill3");
        step(mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0), "kill4");

        repeat (2) @(negedge clk);
        chk("sb_drain", sbq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
